// File: rtl/imem_loader.sv
// imem_loader: fills the instruction memory image at run time from a byte stream.
// Frame = 4-byte little-endian word count N, then N little-endian 32-bit words.
// Each assembled word is written to mem_addr = index*4 for one cycle.
// The CPU is held in reset until all N words are written.
// A header count above DEPTH parks the loader in ERROR until a reload pulse.
module imem_loader #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2480
) (
    input  logic             clock,
    input  logic             nreset,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             reload,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             cpu_hold,
    output logic             done,
    output logic             error
);

    // word_cnt must be able to hold the value DEPTH itself,
    // because it is compared against N after the final increment.
    localparam int WCW = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {
        S_HEADER,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERROR
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [1:0]      byte_cnt;
    logic [WCW-1:0]  word_cnt;
    logic [31:0]     count;
    logic [23:0]     asm_word;

    logic            xfer;
    logic [31:0]     header_word;
    logic [WCW-1:0]  word_next;
    logic            last_word;
    logic [WCW+1:0]  word_addr;

    // The 4th header byte is not yet stored in count,
    // so the full header is completed from the live byte.
    assign header_word = {in_data, count[23:0]};
    assign word_next   = word_cnt + WCW'(1);
    assign last_word   = (32'(word_next) == count);
    assign word_addr   = {word_cnt, 2'b00};
    assign xfer        = in_valid & in_ready;

    // State register; an asynchronous reset abandons any partial frame.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state <= S_HEADER;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and status decode.
    // in_valid is used directly (rather than xfer) to keep in_ready out of its own fan-in.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        cpu_hold   = 1'b1;
        done       = 1'b0;
        error      = 1'b0;
        case (state)
            S_HEADER: begin
                in_ready = 1'b1;
                if (in_valid && byte_cnt == 2'd3) begin
                    if (header_word == 32'd0) begin
                        state_next = S_DONE;
                    end else if (header_word > 32'(DEPTH)) begin
                        state_next = S_ERROR;
                    end else begin
                        state_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                in_ready = 1'b1;
                if (in_valid && byte_cnt == 2'd3) begin
                    state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                state_next = last_word ? S_DONE : S_DATA;
            end
            S_DONE: begin
                cpu_hold = 1'b0;
                done     = 1'b1;
                if (reload) begin
                    state_next = S_HEADER;
                end
            end
            S_ERROR: begin
                error = 1'b1;
                if (reload) begin
                    state_next = S_HEADER;
                end
            end
            default: begin
                state_next = S_HEADER;
            end
        endcase
    end

    // Byte/word counters, header and word assembly, and the registered write port.
    // mem_addr/mem_wdata are loaded together with mem_we when the last byte lands,
    // and then hold their values until the next word.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            byte_cnt  <= 2'd0;
            word_cnt  <= '0;
            count     <= 32'd0;
            asm_word  <= 24'd0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                S_HEADER: begin
                    if (xfer) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        case (byte_cnt)
                            2'd0:    count[7:0]   <= in_data;
                            2'd1:    count[15:8]  <= in_data;
                            2'd2:    count[23:16] <= in_data;
                            default: count[31:24] <= in_data;
                        endcase
                        if (byte_cnt == 2'd3) begin
                            word_cnt <= '0;
                        end
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        case (byte_cnt)
                            2'd0:    asm_word[7:0]   <= in_data;
                            2'd1:    asm_word[15:8]  <= in_data;
                            2'd2:    asm_word[23:16] <= in_data;
                            default: begin
                                mem_we    <= 1'b1;
                                mem_addr  <= WIDTH'(word_addr);
                                mem_wdata <= WIDTH'({in_data, asm_word});
                            end
                        endcase
                    end
                end
                S_WRITE: begin
                    word_cnt <= word_next;
                end
                S_DONE, S_ERROR: begin
                    if (reload) begin
                        byte_cnt <= 2'd0;
                        word_cnt <= '0;
                        count    <= 32'd0;
                        asm_word <= 24'd0;
                    end
                end
                default: begin
                    byte_cnt <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized stream stimulus for imem_loader, with a byte/word
// counting reference model and a per-cycle compare of all outputs.
module tb_imem_loader;

    localparam int WIDTH = 32;
    localparam int DEPTH = 2480;

    logic             clock    = 1'b0;
    logic             nreset   = 1'b0;
    logic [7:0]       in_data  = 8'd0;
    logic             in_valid = 1'b0;
    logic             reload   = 1'b0;
    logic             in_ready;
    logic             mem_we;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic             cpu_hold;
    logic             done;
    logic             error;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [31:0] exp_q[$];

    // Reference model: bytes of header seen, header value, bytes of current word,
    // words written, and whether a write strobe is due this cycle.
    int          m_hdr     = 0;
    logic [31:0] m_n       = 32'd0;
    int          m_cur     = 0;
    logic [31:0] m_acc     = 32'd0;
    int          m_written = 0;
    bit          m_pend    = 1'b0;
    logic [31:0] m_addr    = 32'd0;
    logic [31:0] m_data    = 32'd0;

    imem_loader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock     (clock),
        .nreset    (nreset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .reload    (reload),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .error     (error)
    );

    always #5 clock = ~clock;

    function automatic bit m_err();
        return (m_hdr == 4) && (m_n > 32'(DEPTH));
    endfunction

    function automatic bit m_done();
        return (m_hdr == 4) && !m_err() && (32'(m_written) == m_n) && !m_pend;
    endfunction

    function automatic bit m_ready();
        return !m_done() && !m_err() && !m_pend;
    endfunction

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Model update: a due write completes, else a reload from a finished
    // state restarts, else an accepted byte is counted into header or word.
    always @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            m_hdr = 0; m_n = 32'd0; m_cur = 0; m_acc = 32'd0;
            m_written = 0; m_pend = 1'b0; m_addr = 32'd0; m_data = 32'd0;
        end else if (m_pend) begin
            m_written++;
            m_pend = 1'b0;
        end else if (reload && (m_done() || m_err())) begin
            m_hdr = 0; m_n = 32'd0; m_cur = 0; m_acc = 32'd0; m_written = 0;
        end else if (in_valid && m_ready()) begin
            if (m_hdr < 4) begin
                m_n = m_n | (32'(in_data) << (8 * m_hdr));
                m_hdr++;
            end else begin
                m_acc = m_acc | (32'(in_data) << (8 * m_cur));
                m_cur++;
                if (m_cur == 4) begin
                    m_pend = 1'b1;
                    m_addr = 32'(m_written * 4);
                    m_data = m_acc;
                    m_acc  = 32'd0;
                    m_cur  = 0;
                end
            end
        end
    end

    // Per-cycle compare against the model, plus a log of every write seen.
    always @(negedge clock) begin
        check_output("ctrl{ready,we,hold,done,err}",
                     64'({in_ready, mem_we, cpu_hold, done, error}),
                     64'({m_ready(), m_pend, !m_done(), m_done(), m_err()}));
        check_output("port{addr,wdata}", {mem_addr, mem_wdata}, {m_addr, m_data});
        if (mem_we) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gmin, input int gmax);
        int  idle;
        int  cyc;
        bit  got;
        idle = $urandom_range(gmax, gmin);
        repeat (idle) begin
            in_valid = 1'b0;
            @(posedge clock); #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 64) begin
            @(negedge clock);
            got = in_ready;
            @(posedge clock); #1;
            cyc++;
        end
        in_valid = 1'b0;
        if (!got) check_output("handshake_timeout", 64'(got), 64'd1);
    endtask

    task automatic send_word(input logic [31:0] w, input int gmin, input int gmax);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gmin, gmax);
    endtask

    task automatic pulse_reload();
        in_valid = 1'b0;
        reload   = 1'b1;
        @(posedge clock); #1;
        reload   = 1'b0;
    endtask

    task automatic wait_finished(input int limit);
        int cyc;
        cyc = 0;
        @(negedge clock);
        while (!(done || error) && cyc < limit) begin
            @(negedge clock);
            cyc++;
        end
        #1;
    endtask

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
        exp_q.delete();
    endtask

    // Sends a random frame of n words, logging the expected words.
    task automatic random_frame(input int n, input int gmin, input int gmax, input bit poke_reload);
        logic [31:0] w;
        send_word(32'(n), gmin, gmax);
        for (int i = 0; i < n; i++) begin
            w = $urandom;
            exp_q.push_back(w);
            send_word(w, gmin, gmax);
            if (poke_reload && i == 0) pulse_reload();
        end
    endtask

    task automatic check_log(input string name);
        int bad;
        bad = 0;
        check_output({name, "_count"}, 64'(wr_addr_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < wr_addr_q.size() && i < exp_q.size(); i++) begin
            if (wr_addr_q[i] !== 32'(i * 4) || wr_data_q[i] !== exp_q[i]) bad++;
        end
        check_output({name, "_bad_words"}, 64'(bad), 64'd0);
    endtask

    initial begin
        // Reset values while nreset is held low.
        @(negedge clock);
        check_output("reset_in_ready", 64'(in_ready), 64'd1);
        check_output("reset_cpu_hold", 64'(cpu_hold), 64'd1);
        check_output("reset_flags", 64'({mem_we, done, error}), 64'd0);
        check_output("reset_port", {mem_addr, mem_wdata}, 64'd0);
        @(posedge clock); #1;
        nreset = 1'b1;

        // Empty image: done right after the 4 header bytes.
        send_word(32'd0, 0, 0);
        @(negedge clock); #1;
        check_output("n0_done", 64'(done), 64'd1);
        check_output("n0_cpu_hold", 64'(cpu_hold), 64'd0);
        check_output("n0_in_ready", 64'(in_ready), 64'd0);
        check_output("n0_writes", 64'(wr_addr_q.size()), 64'd0);

        // Two-word image, back-to-back and with in_valid toggling.
        for (int pass = 0; pass < 2; pass++) begin
            pulse_reload();
            clear_log();
            send_word(32'd2, pass, pass);
            send_word(32'h0000_0013, pass, pass);
            send_word(32'h0000_10B7, pass, pass);
            wait_finished(20);
            check_output("n2_done", 64'(done), 64'd1);
            check_output("n2_count", 64'(wr_addr_q.size()), 64'd2);
            if (wr_addr_q.size() == 2) begin
                check_output("n2_w0", {wr_addr_q[0], wr_data_q[0]}, {32'h0, 32'h0000_0013});
                check_output("n2_w1", {wr_addr_q[1], wr_data_q[1]}, {32'h4, 32'h0000_10B7});
            end
        end

        // Oversized header, then recovery via reload.
        pulse_reload();
        clear_log();
        send_word(32'h0000_09B1, 0, 0);
        repeat (3) @(negedge clock);
        #1;
        check_output("ovf_error", 64'(error), 64'd1);
        check_output("ovf_hold_ready", 64'({cpu_hold, in_ready}), 64'b10);
        check_output("ovf_writes", 64'(wr_addr_q.size()), 64'd0);
        pulse_reload();
        @(negedge clock); #1;
        check_output("ovf_reload_error", 64'(error), 64'd0);
        random_frame(1, 0, 2, 1'b0);
        wait_finished(40);
        check_log("ovf_recover");

        // Asynchronous reset part-way through a word.
        pulse_reload();
        clear_log();
        send_word(32'd2, 0, 0);
        send_byte(8'h11, 0, 0);
        send_byte(8'h22, 0, 0);
        #2;
        nreset = 1'b0;
        #1;
        check_output("async_ready_hold", 64'({in_ready, cpu_hold}), 64'b11);
        check_output("async_flags", 64'({mem_we, done, error}), 64'd0);
        check_output("async_port", {mem_addr, mem_wdata}, 64'd0);
        @(posedge clock); #3;
        nreset = 1'b1;
        send_word(32'd1, 0, 0);
        send_word(32'hDDCC_BBAA, 0, 0);
        wait_finished(20);
        check_output("post_reset_count", 64'(wr_addr_q.size()), 64'd1);
        if (wr_addr_q.size() == 1)
            check_output("post_reset_w0", {wr_addr_q[0], wr_data_q[0]}, {32'h0, 32'hDDCC_BBAA});

        // Random small frames; a reload mid-frame must be ignored.
        for (int k = 0; k < 6; k++) begin
            pulse_reload();
            clear_log();
            random_frame($urandom_range(6, 1), 0, 3, k[0]);
            wait_finished(40);
            check_output("rand_done", 64'(done), 64'd1);
            check_log("rand");
        end

        // Full-depth image.
        pulse_reload();
        clear_log();
        random_frame(DEPTH, 0, 1, 1'b0);
        wait_finished(40);
        check_output("depth_done", 64'(done), 64'd1);
        check_log("depth");
        if (wr_addr_q.size() > 0)
            check_output("depth_last_addr", 64'(wr_addr_q[wr_addr_q.size()-1]), 64'h26BC);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
